gx_reset_seq: RTL and testbench

//  Per-channel reset sequencer driving the tx/rx analog and digital resets of the 5-channel GX transceiver bank.

---
 rtl/gx_reset_pkg.sv | 30 +++
 rtl/gx_reset_chan.sv | 238 +++++++++++++++++++++++
 rtl/gx_reset_seq.sv | 70 +++++++
 tb/tb_gx_reset_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gx_reset_pkg.sv
// gx_reset_pkg: shared types and helpers for the GX bank reset sequencer.
//   tx_state_t / rx_state_t : per-channel TX and RX sequencer states
//   cnt_width()             : bits needed to hold the largest timer value
package gx_reset_pkg;

  typedef enum logic [1:0] {
    TX_ANA,
    TX_WAIT,
    TX_DIG,
    TX_RDY
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_ANA,
    RX_CAL,
    RX_CDR,
    RX_DIG,
    RX_RDY
  } rx_state_t;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gx_reset_chan.sv
// gx_reset_chan: TX and RX reset sequencers for one transceiver channel.
// Ports:
//   clock, reset        management clock, async active-high reset
//   pll_locked_s        TX PLL lock, already synchronized by the top
//   tx/rx_reset_req     soft reset requests (synchronous level)
//   tx/rx_cal_busy      calibration busy (async, synchronized here)
//   rx_is_lockedtodata  CDR lock (async, synchronized here)
//   tx/rx_*reset        registered resets to the bank
//   tx/rx_ready         registered datapath-usable flags
//
// state   | meaning
// TX_ANA  | analog+digital reset held, timing minimum analog pulse
// TX_WAIT | waiting for PLL lock and TX calibration done
// TX_DIG  | analog released, timing digital hold
// TX_RDY  | all released, tx_ready high
// RX_ANA  | analog+digital reset held, timing minimum analog pulse
// RX_CAL  | waiting for RX calibration done
// RX_CDR  | analog released, qualifying lock-to-data, timeout running
// RX_DIG  | lock qualified, timing digital hold
// RX_RDY  | all released, rx_ready high
module gx_reset_chan
  import gx_reset_pkg::*;
#(
  parameter int T_ANALOG_CYC   = 100,
  parameter int T_DIGITAL_CYC  = 100,
  parameter int T_LTD_CYC      = 500,
  parameter int RX_TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pll_locked_s,
  input  logic tx_reset_req,
  input  logic rx_reset_req,
  input  logic tx_cal_busy,
  input  logic rx_cal_busy,
  input  logic rx_is_lockedtodata,
  output logic tx_analogreset,
  output logic tx_digitalreset,
  output logic rx_analogreset,
  output logic rx_digitalreset,
  output logic tx_ready,
  output logic rx_ready
);

  localparam int CW = cnt_width(T_ANALOG_CYC, T_DIGITAL_CYC, T_LTD_CYC, RX_TIMEOUT_CYC);
  localparam logic [CW-1:0] ANA_TC = CW'(T_ANALOG_CYC);
  localparam logic [CW-1:0] DIG_TC = CW'(T_DIGITAL_CYC);
  localparam logic [CW-1:0] LTD_TC = CW'(T_LTD_CYC);
  localparam logic [CW-1:0] TO_TC  = CW'(RX_TIMEOUT_CYC);
  // Busy flags come out of reset as "busy" so nothing advances on stale sync data.
  localparam logic [2:0] SYNC_RST = 3'b011;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // bit0 tx_cal_busy, bit1 rx_cal_busy, bit2 rx_is_lockedtodata
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic tx_busy_s, rx_busy_s, rx_lock_s;

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] ltd_cnt_q, ltd_cnt_d;
  logic tx_ana_q, tx_ana_d, tx_dig_q, tx_dig_d, tx_rdy_q, tx_rdy_d;
  logic rx_ana_q, rx_ana_d, rx_dig_q, rx_dig_d, rx_rdy_q, rx_rdy_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign tx_busy_s = sync_q[SYNC_STAGES-1][0];
  assign rx_busy_s = sync_q[SYNC_STAGES-1][1];
  assign rx_lock_s = sync_q[SYNC_STAGES-1][2];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      TX_ANA: begin
        if (tx_cnt_q == ANA_TC) begin
          tx_state_d = TX_WAIT;
          tx_cnt_d   = '0;
        end else tx_cnt_d = sat_inc(tx_cnt_q);
      end
      TX_WAIT: begin
        if (pll_locked_s && !tx_busy_s) begin
          tx_state_d = TX_DIG;
          tx_cnt_d   = '0;
        end
      end
      TX_DIG: begin
        if (!pll_locked_s) begin
          tx_state_d = TX_ANA;
          tx_cnt_d   = '0;
        end else if (tx_cnt_q == DIG_TC) begin
          tx_state_d = TX_RDY;
          tx_cnt_d   = '0;
        end else tx_cnt_d = sat_inc(tx_cnt_q);
      end
      TX_RDY: begin
        if (!pll_locked_s) begin
          tx_state_d = TX_ANA;
          tx_cnt_d   = '0;
        end else if (tx_busy_s) begin
          tx_state_d = TX_WAIT;
          tx_cnt_d   = '0;
        end
      end
      default: begin
        tx_state_d = TX_ANA;
        tx_cnt_d   = '0;
      end
    endcase
    if (tx_reset_req) begin
      tx_state_d = TX_ANA;
      tx_cnt_d   = '0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    ltd_cnt_d  = ltd_cnt_q;
    case (rx_state_q)
      RX_ANA: begin
        if (rx_cnt_q == ANA_TC) begin
          rx_state_d = RX_CAL;
          rx_cnt_d   = '0;
        end else rx_cnt_d = sat_inc(rx_cnt_q);
      end
      RX_CAL: begin
        if (!rx_busy_s) begin
          rx_state_d = RX_CDR;
          rx_cnt_d   = '0;
          ltd_cnt_d  = '0;
        end
      end
      RX_CDR: begin
        // rx_cnt is the lock timeout here; ltd_cnt counts consecutive locked cycles.
        ltd_cnt_d = rx_lock_s ? sat_inc(ltd_cnt_q) : '0;
        rx_cnt_d  = sat_inc(rx_cnt_q);
        if (ltd_cnt_q == LTD_TC) begin
          rx_state_d = RX_DIG;
          rx_cnt_d   = '0;
          ltd_cnt_d  = '0;
        end else if (rx_cnt_q == TO_TC) begin
          rx_state_d = RX_ANA;
          rx_cnt_d   = '0;
          ltd_cnt_d  = '0;
        end
      end
      RX_DIG: begin
        if (!rx_lock_s) begin
          rx_state_d = RX_CDR;
          rx_cnt_d   = '0;
          ltd_cnt_d  = '0;
        end else if (rx_cnt_q == DIG_TC) begin
          rx_state_d = RX_RDY;
          rx_cnt_d   = '0;
        end else rx_cnt_d = sat_inc(rx_cnt_q);
      end
      RX_RDY: begin
        if (!rx_lock_s) begin
          rx_state_d = RX_CDR;
          rx_cnt_d   = '0;
          ltd_cnt_d  = '0;
        end else if (rx_busy_s) begin
          rx_state_d = RX_CAL;
          rx_cnt_d   = '0;
        end
      end
      default: begin
        rx_state_d = RX_ANA;
        rx_cnt_d   = '0;
        ltd_cnt_d  = '0;
      end
    endcase
    if (rx_reset_req) begin
      rx_state_d = RX_ANA;
      rx_cnt_d   = '0;
      ltd_cnt_d  = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state register.
  always_comb begin
    tx_ana_d = (tx_state_d == TX_ANA) || (tx_state_d == TX_WAIT);
    tx_rdy_d = (tx_state_d == TX_RDY);
    tx_dig_d = !tx_rdy_d;
    rx_ana_d = (rx_state_d == RX_ANA) || (rx_state_d == RX_CAL);
    rx_rdy_d = (rx_state_d == RX_RDY);
    rx_dig_d = !rx_rdy_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      tx_state_q <= TX_ANA;
      rx_state_q <= RX_ANA;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ltd_cnt_q  <= '0;
      tx_ana_q   <= 1'b1;
      tx_dig_q   <= 1'b1;
      tx_rdy_q   <= 1'b0;
      rx_ana_q   <= 1'b1;
      rx_dig_q   <= 1'b1;
      rx_rdy_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      ltd_cnt_q  <= ltd_cnt_d;
      tx_ana_q   <= tx_ana_d;
      tx_dig_q   <= tx_dig_d;
      tx_rdy_q   <= tx_rdy_d;
      rx_ana_q   <= rx_ana_d;
      rx_dig_q   <= rx_dig_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  assign tx_analogreset  = tx_ana_q;
  assign tx_digitalreset = tx_dig_q;
  assign tx_ready        = tx_rdy_q;
  assign rx_analogreset  = rx_ana_q;
  assign rx_digitalreset = rx_dig_q;
  assign rx_ready        = rx_rdy_q;

endmodule

// File: rtl/gx_reset_seq.sv
// gx_reset_seq: reset sequencer for the GX transceiver bank.
// Ports:
//   clock, reset                management clock, async active-high reset
//   tx/rx_reset_req[NUM_CH]     per-channel soft reset requests
//   pll_locked                  TX PLL lock (async, one shared synchronizer)
//   tx/rx_cal_busy[NUM_CH]      calibration busy (async)
//   rx_is_lockedtodata[NUM_CH]  CDR lock (async)
//   tx/rx_analogreset, tx/rx_digitalreset, tx/rx_ready [NUM_CH] outputs
module gx_reset_seq
  import gx_reset_pkg::*;
#(
  parameter int NUM_CH         = 5,
  parameter int T_ANALOG_CYC   = 100,
  parameter int T_DIGITAL_CYC  = 100,
  parameter int T_LTD_CYC      = 500,
  parameter int RX_TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] tx_reset_req,
  input  logic [NUM_CH-1:0] rx_reset_req,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] tx_cal_busy,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  output logic [NUM_CH-1:0] tx_analogreset,
  output logic [NUM_CH-1:0] tx_digitalreset,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic [NUM_CH-1:0] tx_ready,
  output logic [NUM_CH-1:0] rx_ready
);

  // One synchronizer feeds every channel so a PLL drop hits all TX FSMs on the same edge.
  logic [SYNC_STAGES-1:0] pll_sync_q, pll_sync_d;

  always_comb pll_sync_d = {pll_sync_q[SYNC_STAGES-2:0], pll_locked};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pll_sync_q <= '0;
    else       pll_sync_q <= pll_sync_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gx_reset_chan #(
      .T_ANALOG_CYC  (T_ANALOG_CYC),
      .T_DIGITAL_CYC (T_DIGITAL_CYC),
      .T_LTD_CYC     (T_LTD_CYC),
      .RX_TIMEOUT_CYC(RX_TIMEOUT_CYC),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_chan (
      .clock             (clock),
      .reset             (reset),
      .pll_locked_s      (pll_sync_q[SYNC_STAGES-1]),
      .tx_reset_req      (tx_reset_req[c]),
      .rx_reset_req      (rx_reset_req[c]),
      .tx_cal_busy       (tx_cal_busy[c]),
      .rx_cal_busy       (rx_cal_busy[c]),
      .rx_is_lockedtodata(rx_is_lockedtodata[c]),
      .tx_analogreset    (tx_analogreset[c]),
      .tx_digitalreset   (tx_digitalreset[c]),
      .rx_analogreset    (rx_analogreset[c]),
      .rx_digitalreset   (rx_digitalreset[c]),
      .tx_ready          (tx_ready[c]),
      .rx_ready          (rx_ready[c])
    );
  end

endmodule

// File: tb/tb_gx_reset_seq.sv
// tb_gx_reset_seq: timeline scoreboard bench for gx_reset_seq.
// Expectations are queued with the cycle (edges after reset release) at which
// they must hold; a negedge monitor pops and compares them.
module tb_gx_reset_seq;

  localparam int N = 5;
  localparam int F_TXA = 0, F_TXD = 1, F_RXA = 2, F_RXD = 3, F_TXR = 4, F_RXR = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] tx_reset_req, rx_reset_req, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata;
  logic pll_locked;
  logic [N-1:0] tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready;
  logic [29:0] snap, rst_exp;

  gx_reset_seq #(
    .NUM_CH(N), .T_ANALOG_CYC(4), .T_DIGITAL_CYC(4), .T_LTD_CYC(8),
    .RX_TIMEOUT_CYC(64), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .tx_reset_req(tx_reset_req), .rx_reset_req(rx_reset_req),
    .pll_locked(pll_locked), .tx_cal_busy(tx_cal_busy), .rx_cal_busy(rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .tx_analogreset(tx_analogreset), .tx_digitalreset(tx_digitalreset),
    .rx_analogreset(rx_analogreset), .rx_digitalreset(rx_digitalreset),
    .tx_ready(tx_ready), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  assign snap = {rx_ready, tx_ready, rx_digitalreset, rx_analogreset, tx_digitalreset, tx_analogreset};

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int          at;
    logic [29:0] mask;
    logic [29:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err = 0;
  int rel;

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc - rel, obs, exp_v);
    end
  endtask

  task automatic expect_at(input string tag, input int at, input int fld,
                           input logic [4:0] chm, input logic [4:0] v);
    exp_t e;
    int   i;
    e.tag  = tag;
    e.at   = rel + at;
    e.mask = 30'(chm) << (5 * fld);
    e.val  = 30'(v) << (5 * fld);
    i = 0;
    while (i < sb.size() && sb[i].at <= e.at) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, snap & e.mask, e.val & e.mask);
    end
  end

  task automatic wait_to(input int k);
    while (cyc < rel + k) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, q, r;
    rst_exp            = {10'b0, 20'hFFFFF};
    tx_reset_req       = '0;
    rx_reset_req       = '0;
    pll_locked         = 1'b1;
    tx_cal_busy        = '0;
    rx_cal_busy        = 5'b00010;
    rx_is_lockedtodata = '1;
    rel                = 0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_state", snap, rst_exp);
    reset = 1'b0;
    rel   = cyc;

    // bring-up; ch1 held in RX calibration
    expect_at("tx_ana_hi", 5, F_TXA, 5'b11111, 5'b11111);
    expect_at("tx_ana_lo", 6, F_TXA, 5'b11111, 5'b00000);
    expect_at("tx_dig_hi", 6, F_TXD, 5'b11111, 5'b11111);
    expect_at("tx_rdy_lo", 10, F_TXR, 5'b11111, 5'b00000);
    expect_at("tx_rdy_hi", 11, F_TXR, 5'b11111, 5'b11111);
    expect_at("tx_dig_lo", 11, F_TXD, 5'b11111, 5'b00000);
    expect_at("rx_ana_lo", 6, F_RXA, 5'b11101, 5'b00000);
    expect_at("c1_ana_6", 6, F_RXA, 5'b00010, 5'b00010);
    expect_at("rx_dig_hi", 14, F_RXD, 5'b11101, 5'b11101);
    expect_at("rx_rdy_lo", 19, F_RXR, 5'b11101, 5'b00000);
    expect_at("rx_rdy_hi", 20, F_RXR, 5'b11101, 5'b11101);
    expect_at("rx_dig_lo", 20, F_RXD, 5'b11101, 5'b00000);
    expect_at("c1_ana_100", 100, F_RXA, 5'b00010, 5'b00010);
    expect_at("c1_ana_202", 202, F_RXA, 5'b00010, 5'b00010);
    expect_at("c1_ana_rel", 203, F_RXA, 5'b00010, 5'b00000);
    expect_at("c1_rdy_lo", 216, F_RXR, 5'b00010, 5'b00000);
    expect_at("c1_rdy_hi", 217, F_RXR, 5'b00010, 5'b00010);
    wait_to(200);
    rx_cal_busy[1] = 1'b0;

    // PLL lock glitch
    p = 230;
    expect_at("pll_rdy_pre", p + 2, F_TXR, 5'b11111, 5'b11111);
    expect_at("pll_rdy_drop", p + 3, F_TXR, 5'b11111, 5'b00000);
    expect_at("pll_ana_set", p + 3, F_TXA, 5'b11111, 5'b11111);
    expect_at("pll_rx_keep", p + 3, F_RXR, 5'b11111, 5'b11111);
    expect_at("pll_wait_ana", p + 8, F_TXA, 5'b11111, 5'b11111);
    expect_at("pll_dig_ana", p + 9, F_TXA, 5'b11111, 5'b00000);
    expect_at("pll_rdy_lo2", p + 13, F_TXR, 5'b11111, 5'b00000);
    expect_at("pll_rdy_back", p + 14, F_TXR, 5'b11111, 5'b11111);
    expect_at("pll_rx_keep2", p + 14, F_RXR, 5'b11111, 5'b11111);
    wait_to(p);
    pll_locked = 1'b0;
    wait_to(p + 3);
    pll_locked = 1'b1;

    // RX soft reset on ch2
    q = 260;
    expect_at("req_rdy_lo", q + 1, F_RXR, 5'b11111, 5'b11011);
    expect_at("req_ana_hi", q + 1, F_RXA, 5'b11111, 5'b00100);
    expect_at("req_dig_hi", q + 1, F_RXD, 5'b11111, 5'b00100);
    expect_at("req_hold", q + 10, F_RXA, 5'b00100, 5'b00100);
    expect_at("req_ana_end", q + 15, F_RXA, 5'b00100, 5'b00100);
    expect_at("req_cdr", q + 16, F_RXA, 5'b00100, 5'b00000);
    expect_at("req_rdy_lo2", q + 29, F_RXR, 5'b00100, 5'b00000);
    expect_at("req_rdy_back", q + 30, F_RXR, 5'b11111, 5'b11111);
    wait_to(q);
    rx_reset_req[2] = 1'b1;
    wait_to(q + 10);
    rx_reset_req[2] = 1'b0;

    // CDR timeout on ch3 with flapping lock, then recovery and async reset in RX_DIG
    r = 300;
    expect_at("to_rdy_lo", r + 1, F_RXR, 5'b01000, 5'b00000);
    expect_at("to_in_cdr_a", r + 40, F_RXA, 5'b01000, 5'b00000);
    expect_at("to_in_cdr_d", r + 40, F_RXD, 5'b01000, 5'b01000);
    expect_at("to_pre", r + 71, F_RXA, 5'b01000, 5'b00000);
    expect_at("to_ana_hi", r + 72, F_RXA, 5'b01000, 5'b01000);
    expect_at("to_others", r + 72, F_RXR, 5'b10111, 5'b10111);
    expect_at("to_ana_hold", r + 75, F_RXA, 5'b01000, 5'b01000);
    expect_at("to_cdr2", r + 78, F_RXA, 5'b01000, 5'b00000);
    expect_at("c3_dig_d", r + 88, F_RXD, 5'b01000, 5'b01000);
    expect_at("c3_dig_r", r + 88, F_RXR, 5'b01000, 5'b00000);
    wait_to(r);
    rx_reset_req[3]       = 1'b1;
    rx_is_lockedtodata[3] = 1'b0;
    wait_to(r + 1);
    rx_reset_req[3] = 1'b0;
    for (int m = 1; m <= 15; m++) begin
      wait_to(r + 5 * m);
      rx_is_lockedtodata[3] = m[0];
    end
    wait_to(r + 88);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", snap, rst_exp);
    chk("sb_drain", 30'(sb.size()), 30'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("post_rst", snap, rst_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
